// File: rtl/i2c_slave_responder.sv
// I2C target answering one 7-bit address: filtered SCL/SDA sampling, START/STOP detection,
// write-byte streaming and read-byte transmission. Define I2C_SLAVE_STRETCH_EN for SCL stretching.
module i2c_slave_responder #(
  parameter int FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] device_address,
  input  logic       enable,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  output logic       data_out_first,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_t,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  output logic       busy,
  output logic       bus_active
);

`ifdef I2C_SLAVE_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] FLT_LOAD = CW'(FILTER_LEN - 1);

  // state      | meaning
  // IDLE       | no transfer for us, lines released
  // ADDRESS    | shifting in address byte (bit0 = R/nW)
  // ADDR_ACK   | ACK/NACK our address, then branch on R/nW
  // WRITE_DATA | shifting in a master-written byte
  // WRITE_ACK  | strobe data_out and ACK the byte
  // READ_DATA  | driving a byte MSB first
  // READ_ACK   | sampling master ACK/NACK
  // READ_STALL | SCL held low waiting for data_in_valid
  // IGNORE     | off-bus until START/STOP
  typedef enum logic [3:0] {
    IDLE, ADDRESS, ADDR_ACK, WRITE_DATA, WRITE_ACK,
    READ_DATA, READ_ACK, READ_STALL, IGNORE
  } state_t;

  state_t state;
  logic [1:0] meta, sync, filt, filt_q;   // bit1 = SCL, bit0 = SDA
  logic [1:0][CW-1:0] fcnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       ack_drv;
  logic       nack;
  logic       first;

  assign scl_o = 1'b0;
  assign sda_o = 1'b0;

  // Each filtered line follows its synchronised copy only after FILTER_LEN differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 2'b11;
      sync   <= 2'b11;
      filt   <= 2'b11;
      filt_q <= 2'b11;
      fcnt   <= {2{FLT_LOAD}};
    end else begin
      meta   <= {scl_i, sda_i};
      sync   <= meta;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == filt[i]) begin
          fcnt[i] <= FLT_LOAD;
        end else if (fcnt[i] == '0) begin
          filt[i] <= sync[i];
          fcnt[i] <= FLT_LOAD;
        end else begin
          fcnt[i] <= fcnt[i] - 1'b1;
        end
      end
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] next_byte;

  assign scl_rise  = filt[1] & ~filt_q[1];
  assign scl_fall  = ~filt[1] & filt_q[1];
  assign start_det = filt[1] & filt_q[1] & filt_q[0] & ~filt[0];
  assign stop_det  = filt[1] & filt_q[1] & ~filt_q[0] & filt[0];
  assign next_byte = data_in_valid ? data_in : 8'hFF;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bit_cnt        <= 3'd0;
      shreg          <= 8'h00;
      ack_drv        <= 1'b0;
      nack           <= 1'b0;
      first          <= 1'b0;
      sda_t          <= 1'b1;
      scl_t          <= 1'b1;
      busy           <= 1'b0;
      bus_active     <= 1'b0;
      data_out       <= 8'h00;
      data_out_valid <= 1'b0;
      data_out_first <= 1'b0;
      data_in_ready  <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;
      data_in_ready  <= 1'b0;
      // write-byte stretch covers the strobe cycle and the one after it
      scl_t          <= !(STRETCH && data_out_valid);

      case (state)
        ADDRESS, WRITE_DATA: begin
          if (scl_rise) begin
            shreg   <= {shreg[6:0], filt[0]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state   <= (state == ADDRESS) ? ADDR_ACK : WRITE_ACK;
              ack_drv <= 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_drv) begin
              if (enable && shreg[7:1] == device_address) begin
                sda_t   <= 1'b0;
                ack_drv <= 1'b1;
                busy    <= 1'b1;
              end else begin
                state <= IGNORE;
                busy  <= 1'b0;
              end
            end else if (shreg[0]) begin
              bit_cnt <= 3'd0;
              if (STRETCH && !data_in_valid) begin
                scl_t <= 1'b0;
                sda_t <= 1'b1;
                state <= READ_STALL;
              end else begin
                shreg         <= next_byte;
                sda_t         <= next_byte[7];
                data_in_ready <= data_in_valid;
                state         <= READ_DATA;
              end
            end else begin
              sda_t <= 1'b1;
              state <= WRITE_DATA;
            end
          end
        end
        WRITE_ACK: begin
          if (scl_fall) begin
            if (!ack_drv) begin
              data_out       <= shreg;
              data_out_valid <= 1'b1;
              data_out_first <= first;
              first          <= 1'b0;
              sda_t          <= 1'b0;
              ack_drv        <= 1'b1;
              if (STRETCH) scl_t <= 1'b0;
            end else begin
              sda_t <= 1'b1;
              state <= WRITE_DATA;
            end
          end
        end
        READ_DATA: begin
          if (scl_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_t   <= 1'b1;
              ack_drv <= 1'b0;
              state   <= READ_ACK;
            end else begin
              shreg <= {shreg[6:0], 1'b0};
              sda_t <= shreg[6];
            end
          end
        end
        READ_ACK: begin
          if (scl_rise) begin
            ack_drv <= 1'b1;
            nack    <= filt[0];
          end else if (scl_fall && ack_drv) begin
            bit_cnt <= 3'd0;
            if (nack) begin
              state <= IGNORE;
              busy  <= 1'b0;
            end else if (STRETCH && !data_in_valid) begin
              scl_t <= 1'b0;
              state <= READ_STALL;
            end else begin
              shreg         <= next_byte;
              sda_t         <= next_byte[7];
              data_in_ready <= data_in_valid;
              state         <= READ_DATA;
            end
          end
        end
        READ_STALL: begin
          scl_t <= data_in_valid;
          if (data_in_valid) begin
            shreg         <= data_in;
            sda_t         <= data_in[7];
            data_in_ready <= 1'b1;
            state         <= READ_DATA;
          end
        end
        IDLE, IGNORE: ;
        default: state <= IDLE;
      endcase

      if (start_det) begin
        state      <= ADDRESS;
        bit_cnt    <= 3'd0;
        sda_t      <= 1'b1;
        scl_t      <= 1'b1;
        first      <= 1'b1;
        bus_active <= 1'b1;
      end else if (stop_det) begin
        state      <= IDLE;
        sda_t      <= 1'b1;
        scl_t      <= 1'b1;
        busy       <= 1'b0;
        bus_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: bit-banged I2C master with pull-up bus model driving i2c_slave_responder.
module tb_i2c_slave_responder;
  localparam int T = 12;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst = 1'b1;
  logic [6:0] device_address = 7'h50;
  logic       enable = 1'b1;
  logic [7:0] data_out;
  logic       data_out_valid, data_out_first;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       scl_i, scl_o, scl_t, sda_i, sda_o, sda_t;
  logic       busy, bus_active;

  logic scl_m = 1'b1, sda_m = 1'b1, scl_g = 1'b0, sda_g = 1'b0;
  logic glitch_en = 1'b0;
  logic scl_line, sda_line;
  assign scl_line = scl_m & (scl_t | scl_o) & ~scl_g;
  assign sda_line = (sda_m & (sda_t | sda_o)) ^ sda_g;
  assign scl_i = scl_line;
  assign sda_i = sda_line;

  i2c_slave_responder #(.FILTER_LEN(4)) dut (
    .clk(clk), .rst(rst), .device_address(device_address), .enable(enable),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_first(data_out_first),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .scl_i(scl_i), .scl_o(scl_o), .scl_t(scl_t),
    .sda_i(sda_i), .sda_o(sda_o), .sda_t(sda_t),
    .busy(busy), .bus_active(bus_active)
  );

  int n_chk = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // bench-side scoreboards
  logic [7:0] wr_data [16];
  logic       wr_first [16];
  int         wr_n = 0;
  logic [7:0] rd_q [16];
  int         rd_n = 0, rd_idx = 0, rdy_n = 0, stall_n = 0;

  initial forever begin
    @(negedge clk);
    if (data_out_valid && wr_n < 16) begin
      wr_data[wr_n]  = data_out;
      wr_first[wr_n] = data_out_first;
      wr_n++;
    end
    if (data_in_ready) begin
      rd_idx++;
      rdy_n++;
    end
    if (!scl_t) stall_n++;
    data_in_valid = (rd_idx < rd_n);
    data_in       = rd_q[rd_idx % 16];
  end

  task automatic push(input logic [7:0] v);
    rd_q[rd_n % 16] = v;
    rd_n++;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high;
    int k = 0;
    while (!scl_line && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!scl_line) chk("scl_release_timeout", 32'(scl_line), 32'd1);
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    sda_m = b;
    wait_clk(T);
    scl_m = 1'b1;
    wait_scl_high();
    if (glitch_en) begin
      wait_clk(3);
      scl_g = 1'b1; wait_clk(1); scl_g = 1'b0;
      wait_clk(2);
      sda_g = 1'b1; wait_clk(1); sda_g = 1'b0;
      wait_clk(T - 7);
    end else begin
      wait_clk(T);
    end
    r = sda_line;
    scl_m = 1'b0;
    wait_clk(T);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; wait_clk(T);
    scl_m = 1'b1; wait_scl_high(); wait_clk(T);
    sda_m = 1'b0; wait_clk(T);
    scl_m = 1'b0; wait_clk(T);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wait_clk(T);
    scl_m = 1'b1; wait_scl_high(); wait_clk(T);
    sda_m = 1'b1; wait_clk(T);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], r);
    i2c_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(1'b1, b[i]);
    i2c_bit(mack, r);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, r;
    logic [7:0] b;
    int         wb, rb, sb;

    // reset state
    wait_clk(3);
    chk("rst_scl_t", 32'(scl_t), 32'd1);
    chk("rst_sda_t", 32'(sda_t), 32'd1);
    chk("rst_scl_o", 32'(scl_o), 32'd0);
    chk("rst_sda_o", 32'(sda_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bus_active", 32'(bus_active), 32'd0);
    chk("rst_strobes", 32'({data_out_valid, data_in_ready}), 32'd0);
    rst = 1'b0;
    wait_clk(10);

    // 1: write 0xA5, 0x3C to 0x50
    wb = wr_n;
    i2c_start();
    chk("t1_bus_active", 32'(bus_active), 32'd1);
    send_byte(8'hA0, ack); chk("t1_addr_ack", 32'(ack), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    send_byte(8'hA5, ack); chk("t1_d0_ack", 32'(ack), 32'd0);
    send_byte(8'h3C, ack); chk("t1_d1_ack", 32'(ack), 32'd0);
    i2c_stop();
    wait_clk(10);
    chk("t1_count", 32'(wr_n - wb), 32'd2);
    chk("t1_d0", 32'(wr_data[wb]), 32'hA5);
    chk("t1_d0_first", 32'(wr_first[wb]), 32'd1);
    chk("t1_d1", 32'(wr_data[wb+1]), 32'h3C);
    chk("t1_d1_first", 32'(wr_first[wb+1]), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_bus_idle", 32'(bus_active), 32'd0);

    // 2: read 0x96, 0x01 with ACK then NACK
    rb = rdy_n;
    push(8'h96); push(8'h01);
    i2c_start();
    send_byte(8'hA1, ack); chk("t2_addr_ack", 32'(ack), 32'd0);
    recv_byte(1'b0, b); chk("t2_byte0", 32'(b), 32'h96);
    recv_byte(1'b1, b); chk("t2_byte1", 32'(b), 32'h01);
    chk("t2_sda_released", 32'(sda_t), 32'd1);
    i2c_stop();
    wait_clk(5);
    chk("t2_ready_count", 32'(rdy_n - rb), 32'd2);

    // 3: wrong address, then enable=0
    wb = wr_n; rb = rdy_n;
    i2c_start();
    send_byte(8'hA2, ack); chk("t3_wrong_addr_nack", 32'(ack), 32'd1);
    chk("t3_busy_wrong", 32'(busy), 32'd0);
    i2c_stop();
    enable = 1'b0;
    i2c_start();
    send_byte(8'hA0, ack); chk("t3_disabled_nack", 32'(ack), 32'd1);
    chk("t3_busy_dis", 32'(busy), 32'd0);
    i2c_stop();
    enable = 1'b1;
    wait_clk(5);
    chk("t3_no_wr", 32'(wr_n - wb), 32'd0);
    chk("t3_no_rdy", 32'(rdy_n - rb), 32'd0);

    // 4: write 0x11, repeated START, read one byte
    wb = wr_n; rb = rdy_n;
    push(8'h77);
    i2c_start();
    send_byte(8'hA0, ack); chk("t4_waddr_ack", 32'(ack), 32'd0);
    send_byte(8'h11, ack); chk("t4_d_ack", 32'(ack), 32'd0);
    i2c_start();
    send_byte(8'hA1, ack); chk("t4_raddr_ack", 32'(ack), 32'd0);
    recv_byte(1'b1, b); chk("t4_rbyte", 32'(b), 32'h77);
    i2c_stop();
    wait_clk(5);
    chk("t4_wr_count", 32'(wr_n - wb), 32'd1);
    chk("t4_wdata", 32'(wr_data[wb]), 32'h11);
    chk("t4_wfirst", 32'(wr_first[wb]), 32'd1);
    chk("t4_rdy_count", 32'(rdy_n - rb), 32'd1);

    // 5: read with no data available
    rb = rdy_n; sb = stall_n;
    i2c_start();
    send_byte(8'hA1, ack); chk("t5_addr_ack", 32'(ack), 32'd0);
`ifdef I2C_SLAVE_STRETCH_EN
    fork
      begin
        int k = 0;
        while (scl_t && k < 2000) begin
          @(negedge clk);
          k++;
        end
        wait_clk(200);
        push(8'h5A);
      end
    join_none
    recv_byte(1'b1, b);
    chk("t5_byte", 32'(b), 32'h5A);
    chk("t5_rdy", 32'(rdy_n - rb), 32'd1);
    chk("t5_stall_len", 32'((stall_n - sb) >= 200 && (stall_n - sb) <= 206), 32'd1);
`else
    recv_byte(1'b1, b);
    chk("t5_byte", 32'(b), 32'hFF);
    chk("t5_rdy", 32'(rdy_n - rb), 32'd0);
    chk("t5_no_stretch", 32'(stall_n - sb), 32'd0);
`endif
    i2c_stop();
    wait_clk(5);

    // 6a: glitches on SCL and SDA inside every bit
    wb = wr_n;
    glitch_en = 1'b1;
    i2c_start();
    send_byte(8'hA0, ack); chk("t6_addr_ack", 32'(ack), 32'd0);
    send_byte(8'hC3, ack); chk("t6_d_ack", 32'(ack), 32'd0);
    glitch_en = 1'b0;
    i2c_stop();
    wait_clk(5);
    chk("t6_wr_count", 32'(wr_n - wb), 32'd1);
    chk("t6_wdata", 32'(wr_data[wb]), 32'hC3);

    // 6b: reset in the middle of a read while the target drives SDA low
    push(8'h96);
    i2c_start();
    send_byte(8'hA1, ack); chk("t6_raddr_ack", 32'(ack), 32'd0);
    i2c_bit(1'b1, r); chk("t6_rbit7", 32'(r), 32'd1);
    i2c_bit(1'b1, r); chk("t6_rbit6", 32'(r), 32'd0);
    chk("t6_driving_low", 32'(sda_t), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_sda_t", 32'(sda_t), 32'd1);
    chk("t6_rst_scl_t", 32'(scl_t), 32'd1);
    chk("t6_rst_bus_active", 32'(bus_active), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_clk(20);
    chk("t6_bus_active_after_rst", 32'(bus_active), 32'd0);
    i2c_stop();
    wb = wr_n;
    i2c_start();
    send_byte(8'hA0, ack); chk("t6_post_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h42, ack); chk("t6_post_d_ack", 32'(ack), 32'd0);
    i2c_stop();
    wait_clk(5);
    chk("t6_post_wdata", 32'(wr_data[wb]), 32'h42);
    chk("t6_post_first", 32'(wr_first[wb]), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
